// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parametrised synchronous up/down modulo counter
//   CLK      rising-edge clock
//   Reset_n  asynchronous active-low reset (Q = 0, Wrap = 0)
//   Clr      synchronous clear, highest priority
//   Load     synchronous load of D, clamped to MODULUS-1
//   D        load value
//   En       count enable
//   Up       direction, 1 = increment, 0 = decrement
//   Sat      1 = hold at the end value, 0 = wrap modulo MODULUS
//   Q        registered count, always within 0..MODULUS-1
//   TC       combinational terminal count, for cascading into a next stage's En
//   Wrap     registered pulse, high the cycle after a wrapping edge
module sync_updown_counter #(
  parameter int WIDTH = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  input  logic             Up,
  input  logic             Sat,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
  logic [WIDTH-1:0] q_q, q_d;
  logic wrap_q, wrap_d, at_max, at_zero, end_hit;
  assign at_max  = q_q == MAX;
  assign at_zero = q_q == '0;
  // End value depends on direction; the step never runs past it, so a
  // non-power-of-two modulus does not rely on natural overflow.
  assign end_hit = Up ? at_max : at_zero;
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (Clr) q_d = '0;
    else if (Load) q_d = (D > MAX) ? MAX : D;
    else if (En) begin
      q_d    = end_hit ? (Sat ? q_q : (Up ? '0 : MAX)) : (Up ? q_q + WIDTH'(1) : q_q - WIDTH'(1));
      wrap_d = end_hit & ~Sat;
    end
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign TC   = En & end_hit;
endmodule
